// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NREQ producers: round-robin grants (lowest index wins when FIFO_ARB_FIXED_PRIO_EN
// is defined), 1-cycle request-to-write latency, bursts up to MAXBURST; FifoFull stalls the write but keeps the grant.
module fifo_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int WWIDTH   = 8,
  parameter int MAXBURST = 4,
  parameter int BWIDTH   = 3,
  parameter int PWIDTH   = 2
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic [NREQ-1:0]        ReqIn,
  input  logic [NREQ*WWIDTH-1:0] DataIn,
  input  logic [NREQ-1:0]        LastIn,
  output logic [NREQ-1:0]        AckOut,
  output logic [NREQ-1:0]        GrantOut,
  output logic                   Busy,
  input  logic                   FifoFull,
  output logic                   FifoWe,
  output logic [WWIDTH-1:0]      FifoData
);

  typedef enum logic {IDLE, GRANT} stateT;

  stateT             state, stateNext;
  logic [NREQ-1:0]   grantNext;
  logic              busyNext;
  logic [PWIDTH-1:0] ptr, ptrNext;
  logic [PWIDTH-1:0] gIdx, gIdxNext;
  logic [PWIDTH-1:0] sel;
  logic [BWIDTH-1:0] cnt, cntNext;
  logic              anyReq;
  logic              found;
  logic              xfer;
  logic              relGrant;

  // Only the granted requester can be acked; GrantOut is zero in IDLE.
  assign AckOut   = GrantOut & ReqIn & {NREQ{~FifoFull}};
  assign xfer     = |AckOut;
  assign FifoWe   = xfer;
  assign FifoData = DataIn[gIdx*WWIDTH +: WWIDTH];
  assign anyReq   = |ReqIn;

  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && ReqIn[i]) begin
        found = 1'b1;
        sel   = PWIDTH'(i);
      end
    end
`else
    // First pass covers Ptr..NREQ-1, second pass wraps to 0..Ptr-1.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i >= int'(ptr)) && ReqIn[i]) begin
        found = 1'b1;
        sel   = PWIDTH'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i < int'(ptr)) && ReqIn[i]) begin
        found = 1'b1;
        sel   = PWIDTH'(i);
      end
    end
`endif
  end

  always_comb begin
    stateNext = state;
    grantNext = GrantOut;
    busyNext  = Busy;
    ptrNext   = ptr;
    gIdxNext  = gIdx;
    cntNext   = cnt;
    relGrant  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = GRANT;
          grantNext = NREQ'(1) << sel;
          gIdxNext  = sel;
          cntNext   = '0;
          busyNext  = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) cntNext = cnt + 1'b1;
        // A requester with nothing to send only gives up the grant while the FIFO can accept.
        relGrant = (xfer && (LastIn[gIdx] || (cnt == BWIDTH'(MAXBURST - 1))))
                 || (!ReqIn[gIdx] && !FifoFull);
        if (relGrant) begin
          stateNext = IDLE;
          grantNext = '0;
          busyNext  = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
          ptrNext   = '0;
`else
          ptrNext   = (gIdx == PWIDTH'(NREQ - 1)) ? '0 : gIdx + 1'b1;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state    <= IDLE;
      GrantOut <= '0;
      Busy     <= 1'b0;
      ptr      <= '0;
      gIdx     <= '0;
      cnt      <= '0;
    end else begin
      state    <= stateNext;
      GrantOut <= grantNext;
      Busy     <= busyNext;
      ptr      <= ptrNext;
      gIdx     <= gIdxNext;
      cnt      <= cntNext;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: queued requesters feed the DUT, a monitor checks every FIFO write,
// grant order and burst lengths against hand-computed expectations.
module tb_fifo_write_arbiter;
  localparam int NREQ = 3;
  localparam int WW   = 8;
  localparam int LIMIT = 300;

  logic               Clk = 1'b0;
  logic               RstN = 1'b1;
  logic               FifoFull = 1'b0;
  logic [NREQ-1:0]    ReqIn = '0;
  logic [NREQ-1:0]    LastIn = '0;
  logic [NREQ*WW-1:0] DataIn = '0;
  logic [NREQ-1:0]    AckOut, GrantOut;
  logic               Busy, FifoWe;
  logic [WW-1:0]      FifoData;

  fifo_write_arbiter #(.NREQ(3), .WWIDTH(8), .MAXBURST(4), .BWIDTH(3), .PWIDTH(2)) dut (
    .Clk(Clk), .RstN(RstN), .ReqIn(ReqIn), .DataIn(DataIn), .LastIn(LastIn),
    .AckOut(AckOut), .GrantOut(GrantOut), .Busy(Busy), .FifoFull(FifoFull),
    .FifoWe(FifoWe), .FifoData(FifoData)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] mem [NREQ][64];
  int head [NREQ] = '{default: 0};
  int tail [NREQ] = '{default: 0};
  int expQ[$];
  int gLog[$];
  int gCyc[$];
  int bLog[$];
  int cyc = 0;
  int curCnt = 0;
  logic [NREQ-1:0] prevGrant = '0;
  logic [NREQ-1:0] ackS;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void load(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endfunction

  function automatic void expW(input int r, input logic [7:0] d);
    expQ.push_back(r * 256 + int'(d));
  endfunction

  // Requester model: pops acked words after the edge and presents the next head word.
  initial forever begin
    @(negedge Clk);
    ackS = AckOut;
    @(posedge Clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (ackS[i]) head[i]++;
    for (int i = 0; i < NREQ; i++) begin
      ReqIn[i]            = (head[i] != tail[i]);
      DataIn[i*WW +: WW]  = mem[i][head[i]][7:0];
      LastIn[i]           = mem[i][head[i]][8];
    end
  end

  initial begin
    int e;
    logic [2:0] inv;
    forever begin
      @(negedge Clk);
      cyc++;
      inv = {FifoWe & FifoFull, $countones(GrantOut) > 1, FifoWe & ~Busy};
      chk("invariant", int'(inv), 0);
      if (GrantOut != 0 && prevGrant == 0) begin
        for (int i = 0; i < NREQ; i++) if (GrantOut[i]) gLog.push_back(i);
        gCyc.push_back(cyc);
        curCnt = 0;
      end
      if (FifoWe) begin
        curCnt++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got data %0d expected no write", FifoData);
        end else begin
          e = expQ.pop_front();
          chk("wdata", int'(FifoData), e % 256);
          chk("wreq_ack", int'(AckOut), 1 << (e / 256));
        end
      end
      if (GrantOut == 0 && prevGrant != 0) bLog.push_back(curCnt);
      prevGrant = GrantOut;
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((expQ.size() != 0 || GrantOut != 0 || ReqIn != 0) && n < LIMIT) begin
      @(posedge Clk);
      #2;
      n++;
    end
    chk($sformatf("%s_timeout", nm), int'(n >= LIMIT), 0);
    repeat (2) @(posedge Clk);
    #2;
  endtask

  task automatic checkLogs(input string nm, input int eg[$], input int eb[$], input bit spacing);
    chk($sformatf("%s_ngrants", nm), gLog.size(), eg.size());
    for (int i = 0; i < eg.size() && i < gLog.size(); i++)
      chk($sformatf("%s_grant%0d", nm, i), gLog[i], eg[i]);
    chk($sformatf("%s_nbursts", nm), bLog.size(), eb.size());
    for (int i = 0; i < eb.size() && i < bLog.size(); i++)
      chk($sformatf("%s_burst%0d", nm, i), bLog[i], eb[i]);
    if (spacing)
      for (int i = 1; i < gCyc.size(); i++)
        chk($sformatf("%s_gap%0d", nm, i), gCyc[i] - gCyc[i-1], 5);
    gLog.delete();
    bLog.delete();
    gCyc.delete();
  endtask

  initial begin
    #2 RstN = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int k = 1; k <= 8; k++) begin load(0, 8'(k), 1'b0); expW(0, 8'(k)); end
    for (int k = 1; k <= 4; k++) begin load(2, 8'(32 + k), 1'b0); expW(2, 8'(32 + k)); end
`else
    for (int k = 1; k <= 8; k++) load(0, 8'(k), 1'b0);
    for (int k = 1; k <= 4; k++) load(1, 8'(16 + k), 1'b0);
    for (int k = 1; k <= 4; k++) load(2, 8'(32 + k), 1'b0);
    for (int k = 1; k <= 4; k++) expW(0, 8'(k));
    for (int k = 1; k <= 4; k++) expW(1, 8'(16 + k));
    for (int k = 1; k <= 4; k++) expW(2, 8'(32 + k));
    for (int k = 5; k <= 8; k++) expW(0, 8'(k));
`endif
    @(negedge Clk);
    chk("rst_grant", int'(GrantOut), 0);
    chk("rst_we", int'(FifoWe), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ack", int'(AckOut), 0);
    @(posedge Clk);
    #1 RstN = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("first_grant", int'(GrantOut), 1);
    chk("first_busy", int'(Busy), 1);
    drain("bursts");
`ifdef FIFO_ARB_FIXED_PRIO_EN
    checkLogs("fixed", '{0, 0, 2}, '{4, 4, 4}, 1'b1);
`else
    checkLogs("rr", '{0, 1, 2, 0}, '{4, 4, 4, 4}, 1'b1);

    load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b1); load(2, 8'hB1, 1'b1); load(0, 8'hC1, 1'b1);
    expW(1, 8'hA1); expW(1, 8'hA2); expW(2, 8'hB1); expW(0, 8'hC1);
    drain("last");
    checkLogs("last", '{1, 2, 0}, '{2, 1, 1}, 1'b0);

    for (int k = 1; k <= 4; k++) begin load(1, 8'(8'hD0 + k), 1'b0); expW(1, 8'(8'hD0 + k)); end
    repeat (4) @(posedge Clk);
    #2 FifoFull = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      chk("stall_grant", int'(GrantOut), 2);
      chk("stall_we", int'(FifoWe), 0);
      chk("stall_ack", int'(AckOut), 0);
    end
    @(posedge Clk);
    #2 FifoFull = 1'b0;
    drain("stall");
    checkLogs("stall", '{1}, '{4}, 1'b0);

    for (int k = 1; k <= 4; k++) begin load(0, 8'(8'hE0 + k), 1'b0); load(2, 8'(8'hF0 + k), 1'b0); end
    expW(2, 8'hF1); expW(2, 8'hF2);
    for (int k = 1; k <= 4; k++) expW(0, 8'(8'hE0 + k));
    expW(2, 8'hF3); expW(2, 8'hF4);
    repeat (4) @(posedge Clk);
    #2;
    chk("arst_pre_grant", int'(GrantOut), 4);
    RstN = 1'b0;
    #1;
    chk("arst_grant", int'(GrantOut), 0);
    chk("arst_busy", int'(Busy), 0);
    chk("arst_we", int'(FifoWe), 0);
    #1 RstN = 1'b1;
    drain("arst");
    checkLogs("arst", '{2, 0, 2}, '{2, 4, 2}, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
